lcd_timing_ctrl: RTL and testbench
==================================

// Module: lcd_timing_ctrl
// PURPOSE
//   Sequences the LCD panel interface: derives NCLK from CLK, runs the panel power-up reset (GREST),
//   and generates HD/VD/DEN plus pixel coordinates X/Y for the colour-bar/pattern generator downstream.
//   Sits between the system clock domain and the LCD connector; the pattern datapath only maps X/Y -> R/G/B.
// PARAMETERS
//   H_SYNC 1 | H_BP 45 | H_ACT 800 | H_FP 210   horizontal segment lengths, pixel ticks (line = 1056)
//   V_SYNC 1 | V_BP 22 | V_ACT 480 | V_FP 22    vertical segment lengths, lines (frame = 525)
//   PWRUP_CYC 16      pixel ticks GREST held low after reset
//   FRAMES_PER_PAT 60 frames per pattern step (used only with PATTERN_SEQ_EN)
// PORTS
//   CLK          in   1   system clock
//   RST          in   1   synchronous reset, active high
//   EN           in   1   run request; sampled at frame boundaries
//   NCLK         out  1   pixel clock to panel, CLK/2
//   GREST        out  1   panel global reset, active low
//   HD           out  1   horizontal sync, active low
//   VD           out  1   vertical sync, active low
//   DEN          out  1   data enable, high during active area
//   X            out  11  active-area column, 0..H_ACT-1; 0 when DEN=0
//   Y            out  10  active-area row, 0..V_ACT-1; 0 when DEN=0
//   FRAME_START  out  1   one-CLK pulse on the first tick of line 0
//   PAT_SEL      out  2   pattern index to the generator
// BEHAVIOUR
//   - Reset (sync, RST=1 at CLK edge): NCLK=0, GREST=0, HD=1, VD=1, DEN=0, X=Y=0, FRAME_START=0, PAT_SEL=0;
//     FSM -> PWRUP. RST mid-frame aborts immediately; the same values appear on the next CLK edge.
//   - NCLK toggles every CLK. Pixel tick = CLK edge where NCLK==1 (NCLK falls). All panel outputs update only
//     on ticks, so they are stable at NCLK rising edge.
//   - Top FSM: PWRUP -> (PWRUP_CYC ticks) -> IDLE; IDLE -> RUN on a tick with EN=1;
//     RUN -> IDLE on the tick after the last tick of the frame (line 524, H_FP end) if EN=0.
//     GREST=1 in IDLE and RUN. In PWRUP/IDLE: HD=VD=1, DEN=0, counters held at 0.
//   - EN dropping mid-frame: the frame completes; no truncated frame. Rising EN: RUN starts on the next tick at h=0, v=0.
//   - Horizontal FSM per line: SYNC -> BP -> ACT -> FP -> SYNC; segment counter reloads on each transition.
//     HD=0 during SYNC only. Vertical FSM has the same states, advancing once per line at the FP->SYNC wrap.
//     VD=0 for whole lines in V SYNC.
//   - DEN=1 iff H in ACT and V in ACT (registered, same tick as X/Y). X increments per DEN tick;
//     X wraps to 0 at line end; Y increments at the end of each active line and wraps to 0 at frame end.
//   - Line 0 tick 0 of every RUN frame: HD=0, VD=0, FRAME_START=1 for that one CLK.
//   - Counters are sized from the parameters with $clog2; no overflow at max parameter values.
//   - Latency: first DEN tick = (V_SYNC+V_BP)*line + H_SYNC+H_BP ticks after entering RUN.
// CONFIGURATION
//   `PATTERN_SEQ_EN defined: a frame counter counts FRAME_STARTs; after FRAMES_PER_PAT frames PAT_SEL increments,
//     wrapping 3->0. PAT_SEL changes only on the FRAME_START tick. Reset and IDLE hold the count, PAT_SEL=0 after reset.
//   Not defined: PAT_SEL tied to 2'b00; no frame counter logic is generated. Port list is identical in both builds.
// STRUCTURE
//   Package lcd_timing_pkg: seg_t enum {SEG_SYNC, SEG_BP, SEG_ACT, SEG_FP}, top_t enum {PWRUP, IDLE, RUN},
//     default timing localparams for 800x480.
//   Sub-module lcd_axis_counter (params SYNC/BP/ACT/FP; inputs CLK, RST, clear, step; outputs seg, wrap, act_idx),
//     instantiated for H (step = tick) and V (step = H wrap).
//   Top level holds NCLK, the top FSM, output registers and the optional pattern sequencer.
// TESTING (bench params: H 1/2/4/3 = 10 ticks/line, V 1/1/3/1 = 6 lines, PWRUP_CYC 4, FRAMES_PER_PAT 2)
//   1 RST=1 for 3 CLK, EN=1 -> all outputs at reset values; NCLK first rises 1 CLK after RST drops; GREST rises after 4 ticks (8 CLK).
//   2 Run one frame -> HD low 1 tick per line, VD low for line 0 (10 ticks), DEN high 4 ticks in each of lines 2..4, X=0..3, Y=0..2; 12 DEN ticks per frame.
//   3 Frame period -> FRAME_START pulses exactly 60 ticks (120 CLK) apart, each 1 CLK wide, coincident with HD=VD=0.
//   4 EN=0 during line 3 -> frame completes through line 5; then IDLE: HD=VD=1, DEN=0, GREST=1; EN=1 -> next tick is line 0 tick 0 with FRAME_START.
//   5 RST pulse during DEN -> next CLK DEN=0, GREST=0, X=Y=0; full power-up repeats before the next frame.
//   6 With PATTERN_SEQ_EN: 8 frames -> PAT_SEL 0,0,1,1,2,2,3,3 then 0; without the macro PAT_SEL stays 0.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared types and default 800x480 timing for the LCD timing controller.
package lcd_timing_pkg;

  typedef enum logic [1:0] {SEG_SYNC, SEG_BP, SEG_ACT, SEG_FP} seg_t;
  typedef enum logic [1:0] {PWRUP, IDLE, RUN} top_t;

  localparam int unsigned H_SYNC_DEF         = 1;
  localparam int unsigned H_BP_DEF           = 45;
  localparam int unsigned H_ACT_DEF          = 800;
  localparam int unsigned H_FP_DEF           = 210;
  localparam int unsigned V_SYNC_DEF         = 1;
  localparam int unsigned V_BP_DEF           = 22;
  localparam int unsigned V_ACT_DEF          = 480;
  localparam int unsigned V_FP_DEF           = 22;
  localparam int unsigned PWRUP_CYC_DEF      = 16;
  localparam int unsigned FRAMES_PER_PAT_DEF = 60;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// One display axis: walks SYNC -> BP -> ACT -> FP per step, reporting segment, wrap and
// the index within the active segment.
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned SYNC = 1,
  parameter int unsigned BP   = 1,
  parameter int unsigned ACT  = 1,
  parameter int unsigned FP   = 1,
  parameter int unsigned IdxW = 11
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            clear_i,
  input  logic            step_i,
  output logic [1:0]      seg_o,
  output logic            wrap_o,
  output logic [IdxW-1:0] act_idx_o
);

  localparam int unsigned MaxLen = max4(SYNC, BP, ACT, FP);
  localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  seg_t            seg_q, seg_d, seg_nxt;
  logic [CntW-1:0] cnt_q, cnt_d;
  int unsigned     seg_len;
  logic            seg_last;

  always_comb begin
    seg_len = SYNC;
    seg_nxt = SEG_BP;
    unique case (seg_q)
      SEG_SYNC: begin seg_len = SYNC; seg_nxt = SEG_BP;   end
      SEG_BP:   begin seg_len = BP;   seg_nxt = SEG_ACT;  end
      SEG_ACT:  begin seg_len = ACT;  seg_nxt = SEG_FP;   end
      SEG_FP:   begin seg_len = FP;   seg_nxt = SEG_SYNC; end
      default:  ;
    endcase
    seg_last = (32'(cnt_q) == seg_len - 1);

    seg_d = seg_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      seg_d = SEG_SYNC;
      cnt_d = '0;
    end else if (step_i) begin
      if (seg_last) begin
        seg_d = seg_nxt;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_q <= SEG_SYNC;
      cnt_q <= '0;
    end else begin
      seg_q <= seg_d;
      cnt_q <= cnt_d;
    end
  end

  assign seg_o     = seg_q;
  assign wrap_o    = (seg_q == SEG_FP) && seg_last;
  // Within ACT the segment counter already is the column/row index.
  assign act_idx_o = (seg_q == SEG_ACT) ? IdxW'(cnt_q) : '0;

endmodule

// File: rtl/lcd_timing_ctrl.sv
// LCD panel timing: NCLK = CLK/2, power-up GREST sequencing, HD/VD/DEN and X/Y generation.
// Define PATTERN_SEQ_EN to step PAT_SEL every FRAMES_PER_PAT frames; otherwise PAT_SEL is 0.
module lcd_timing_ctrl
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC         = H_SYNC_DEF,
  parameter int unsigned H_BP           = H_BP_DEF,
  parameter int unsigned H_ACT          = H_ACT_DEF,
  parameter int unsigned H_FP           = H_FP_DEF,
  parameter int unsigned V_SYNC         = V_SYNC_DEF,
  parameter int unsigned V_BP           = V_BP_DEF,
  parameter int unsigned V_ACT          = V_ACT_DEF,
  parameter int unsigned V_FP           = V_FP_DEF,
  parameter int unsigned PWRUP_CYC      = PWRUP_CYC_DEF,
  parameter int unsigned FRAMES_PER_PAT = FRAMES_PER_PAT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  output logic        NCLK,
  output logic        GREST,
  output logic        HD,
  output logic        VD,
  output logic        DEN,
  output logic [10:0] X,
  output logic [9:0]  Y,
  output logic        FRAME_START,
  output logic [1:0]  PAT_SEL
);

  localparam int unsigned PwrW = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;

  if (H_ACT > 2048 || V_ACT > 1024 || PWRUP_CYC == 0 || FRAMES_PER_PAT == 0) begin : g_cfg_check
    $error("lcd_timing_ctrl: unsupported timing parameters");
  end

  top_t            state_q;
  logic            nclk_q;
  logic            origin_q;
  logic [PwrW-1:0] pwr_cnt_q;
  logic [1:0]      h_seg, v_seg;
  logic            h_wrap, v_wrap;
  logic [10:0]     h_idx;
  logic [9:0]      v_idx;
  logic            present, clear, den_d;

  // A tick presents the counters' current position; origin_q marks position (0,0).
  assign present = nclk_q && ((state_q == IDLE && EN) || (state_q == RUN && !(origin_q && !EN)));
  assign clear   = !present && (state_q != RUN);
  assign den_d   = (h_seg == SEG_ACT) && (v_seg == SEG_ACT);

  lcd_axis_counter #(
    .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP), .IdxW(11)
  ) u_h_axis (
    .CLK(CLK), .RST(RST), .clear_i(clear), .step_i(present),
    .seg_o(h_seg), .wrap_o(h_wrap), .act_idx_o(h_idx)
  );

  lcd_axis_counter #(
    .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP), .IdxW(10)
  ) u_v_axis (
    .CLK(CLK), .RST(RST), .clear_i(clear), .step_i(present && h_wrap),
    .seg_o(v_seg), .wrap_o(v_wrap), .act_idx_o(v_idx)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= PWRUP;
      nclk_q      <= 1'b0;
      origin_q    <= 1'b1;
      pwr_cnt_q   <= '0;
      GREST       <= 1'b0;
      HD          <= 1'b1;
      VD          <= 1'b1;
      DEN         <= 1'b0;
      X           <= '0;
      Y           <= '0;
      FRAME_START <= 1'b0;
    end else begin
      nclk_q      <= ~nclk_q;
      FRAME_START <= 1'b0;
      if (nclk_q) begin
        unique case (state_q)
          PWRUP: begin
            if (pwr_cnt_q == PwrW'(PWRUP_CYC - 1)) begin
              state_q <= IDLE;
              GREST   <= 1'b1;
            end else begin
              pwr_cnt_q <= pwr_cnt_q + PwrW'(1);
            end
          end
          IDLE:    if (EN) state_q <= RUN;
          RUN:     if (origin_q && !EN) state_q <= IDLE;
          default: state_q <= PWRUP;
        endcase

        if (present) begin
          HD          <= (h_seg != SEG_SYNC);
          VD          <= (v_seg != SEG_SYNC);
          DEN         <= den_d;
          X           <= den_d ? h_idx : '0;
          Y           <= den_d ? v_idx : '0;
          FRAME_START <= origin_q;
          origin_q    <= h_wrap && v_wrap;
        end else begin
          HD       <= 1'b1;
          VD       <= 1'b1;
          DEN      <= 1'b0;
          X        <= '0;
          Y        <= '0;
          origin_q <= 1'b1;
        end
      end
    end
  end

  assign NCLK = nclk_q;

`ifdef PATTERN_SEQ_EN
  localparam int unsigned FcW = $clog2(FRAMES_PER_PAT + 1);

  logic [FcW-1:0] frame_cnt_q;
  logic [1:0]     pat_q;

  // Counts frame starts; the step lands on the first frame after FRAMES_PER_PAT completed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt_q <= '0;
      pat_q       <= 2'b00;
    end else if (present && origin_q) begin
      if (frame_cnt_q == FcW'(FRAMES_PER_PAT)) begin
        pat_q       <= pat_q + 2'd1;
        frame_cnt_q <= FcW'(1);
      end else begin
        frame_cnt_q <= frame_cnt_q + FcW'(1);
      end
    end
  end

  assign PAT_SEL = pat_q;
`else
  assign PAT_SEL = 2'b00;
`endif

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Bench for lcd_timing_ctrl with a small 10x6 raster; a frame-position model checks every cycle.
module tb_lcd_timing_ctrl;

  localparam int HS = 1, HB = 2, HA = 4, HF = 3;
  localparam int VS = 1, VB = 1, VA = 3, VF = 1;
  localparam int PW = 4, FPP = 2;
  localparam int LINE = HS + HB + HA + HF;
  localparam int FRAME = LINE * (VS + VB + VA + VF);

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b1;
  logic        NCLK, GREST, HD, VD, DEN, FRAME_START;
  logic [10:0] X;
  logic [9:0]  Y;
  logic [1:0]  PAT_SEL;

  lcd_timing_ctrl #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
    .PWRUP_CYC(PW), .FRAMES_PER_PAT(FPP)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .NCLK(NCLK), .GREST(GREST), .HD(HD), .VD(VD),
    .DEN(DEN), .X(X), .Y(Y), .FRAME_START(FRAME_START), .PAT_SEL(PAT_SEL)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: position in frame as a flat tick index, outputs derived by arithmetic.
  bit m_nclk, m_grest, m_run, m_fs;
  int m_pw, m_pos, m_frames, m_pat;

  task automatic m_start();
    m_fs  = 1'b1;
    m_pos = 0;
`ifdef PATTERN_SEQ_EN
    m_pat = (m_frames / FPP) % 4;
`else
    m_pat = 0;
`endif
    m_frames++;
  endtask

  always @(posedge CLK) begin : model
    bit tick;
    if (RST) begin
      m_nclk = 0; m_grest = 0; m_run = 0; m_fs = 0;
      m_pw = 0; m_pos = 0; m_frames = 0; m_pat = 0;
    end else begin
      tick   = m_nclk;
      m_nclk = !m_nclk;
      m_fs   = 1'b0;
      if (tick) begin
        if (!m_grest) begin
          m_pw++;
          if (m_pw == PW) m_grest = 1'b1;
        end else if (!m_run) begin
          if (EN) begin m_run = 1'b1; m_start(); end
        end else if (m_pos == FRAME - 1) begin
          if (EN) m_start();
          else m_run = 1'b0;
        end else begin
          m_pos++;
        end
      end
    end
  end

  always @(negedge CLK) begin : compare
    int h, v;
    bit den;
    if (chk_en) begin
      h   = m_pos % LINE;
      v   = m_pos / LINE;
      den = m_run && h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
      check("m_NCLK", NCLK, m_nclk);
      check("m_GREST", GREST, m_grest);
      check("m_HD", HD, !(m_run && h < HS));
      check("m_VD", VD, !(m_run && v < VS));
      check("m_DEN", DEN, den);
      check("m_X", X, den ? h - HS - HB : 0);
      check("m_Y", Y, den ? v - VS - VB : 0);
      check("m_FRAME_START", FRAME_START, m_fs);
      check("m_PAT_SEL", PAT_SEL, m_pat);
    end
  end

  task automatic wait_fs(input int limit, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!FRAME_START && n < limit);
  endtask

  initial begin
    int t0, t1, n, g_at, den_cnt, hd_cnt, vd_cnt, fs_cnt, xmax, ymax, xsum, ysum, first_den;
    int pat_exp[9];
`ifdef PATTERN_SEQ_EN
    pat_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
`else
    pat_exp = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    // Reset held for 3 CLK with EN already high.
    RST = 1'b1; EN = 1'b1;
    @(negedge CLK); chk_en = 1'b1;
    @(negedge CLK); @(negedge CLK);
    check("rst_NCLK", NCLK, 0);
    check("rst_GREST", GREST, 0);
    check("rst_HD", HD, 1);
    check("rst_VD", VD, 1);
    check("rst_DEN", DEN, 0);
    check("rst_XY", {21'd0, X} | {22'd0, Y}, 0);
    check("rst_FRAME_START", FRAME_START, 0);
    check("rst_PAT_SEL", PAT_SEL, 0);

    RST = 1'b0; t0 = cyc;
    @(negedge CLK);
    check("nclk_first_rise", NCLK, 1);
    g_at = -1;
    n = 0;
    while (!FRAME_START && n < 40) begin
      if (GREST && g_at < 0) g_at = cyc - t0;
      @(negedge CLK); n++;
    end
    check("grest_rise_clk", g_at, 8);
    check("first_fs_seen", FRAME_START, 1);
    check("first_fs_clk", cyc - t0, 10);
    check("fs_hd_low", HD, 0);
    check("fs_vd_low", VD, 0);

    // One full frame of samples starting on the FRAME_START cycle.
    t1 = cyc;
    den_cnt = 0; hd_cnt = 0; vd_cnt = 0; fs_cnt = 0;
    xmax = 0; ymax = 0; xsum = 0; ysum = 0; first_den = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (DEN) begin
        den_cnt++;
        xsum += int'(X); ysum += int'(Y);
        if (int'(X) > xmax) xmax = int'(X);
        if (int'(Y) > ymax) ymax = int'(Y);
        if (first_den < 0) first_den = i;
      end
      if (!HD) hd_cnt++;
      if (!VD) vd_cnt++;
      if (FRAME_START) fs_cnt++;
      @(negedge CLK);
    end
    check("den_clk_per_frame", den_cnt, 24);
    check("hd_low_clk", hd_cnt, 12);
    check("vd_low_clk", vd_cnt, 20);
    check("fs_width", fs_cnt, 1);
    check("first_den_clk", first_den, 46);
    check("x_max", xmax, 3);
    check("y_max", ymax, 2);
    check("x_sum", xsum, 36);
    check("y_sum", ysum, 24);
    check("fs_period", FRAME_START && (cyc - t1 == 120), 1);

    // EN drops in line 3; the frame must complete, then the controller idles.
    den_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (DEN) den_cnt++;
      if (i == 65) EN = 1'b0;
      @(negedge CLK);
    end
    check("en_drop_den_clk", den_cnt, 24);
    check("idle_fs", FRAME_START, 0);
    check("idle_hd", HD, 1);
    check("idle_vd", VD, 1);
    check("idle_den", DEN, 0);
    check("idle_grest", GREST, 1);
    fs_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (FRAME_START || !VD) fs_cnt++;
    end
    check("idle_no_frame", fs_cnt, 0);
    EN = 1'b1;
    wait_fs(4, n);
    check("restart_clk", n, 2);
    check("restart_hd", HD, 0);
    check("restart_vd", VD, 0);

    // Reset pulse while DEN is high.
    n = 0;
    while (!DEN && n < 60) begin @(negedge CLK); n++; end
    check("den_before_rst", DEN, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rstp_den", DEN, 0);
    check("rstp_grest", GREST, 0);
    check("rstp_x", X, 0);
    check("rstp_y", Y, 0);
    check("rstp_nclk", NCLK, 0);
    t0 = cyc; g_at = -1; n = 0;
    while (!FRAME_START && n < 40) begin
      @(negedge CLK); n++;
      if (GREST && g_at < 0) g_at = cyc - t0;
    end
    check("rstp_grest_clk", g_at, 8);
    check("rstp_fs_clk", cyc - t0, 10);

    // Pattern index sampled on each of nine consecutive frame starts.
    for (int k = 0; k < 9; k++) begin
      check($sformatf("pat_sel_frame%0d", k), PAT_SEL, pat_exp[k]);
      if (k < 8) begin
        wait_fs(130, n);
        check("pat_fs_seen", FRAME_START, 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
